// File: rtl/bsg_fifo_bypass_rr_sched.sv
// Round-robin scheduler feeding one shared FIFO from num_in_p valid/ready requesters.
// Each cycle at most one requester is granted; its word is stored with a source tag and the
// oldest word is offered downstream with valid/yumi.
// Optional feature: define BSG_FIFO_BYPASS_RR_SCHED_BYPASS_EN to let a granted word pass
// straight to the output in the same cycle while storage is empty.
module bsg_fifo_bypass_rr_sched #(
   parameter int unsigned width_p  = 8,  // payload width; set explicitly by the instantiator
   parameter int unsigned num_in_p = 4,
   parameter int unsigned els_p    = 4,
   localparam int unsigned TagW    = (num_in_p > 1) ? $clog2(num_in_p) : 1,
   localparam int unsigned CntW    = $clog2(els_p + 1)
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic [num_in_p*width_p-1:0]  data_i,
   input  logic [num_in_p-1:0]          v_i,
   output logic [num_in_p-1:0]          ready_o,
   output logic [width_p-1:0]           data_o,
   output logic [TagW-1:0]              tag_o,
   output logic                         v_o,
   input  logic                         yumi_i,
   output logic [CntW-1:0]              count_o
);

   localparam int unsigned PtrW = $clog2(els_p);
   localparam int unsigned EntW = TagW + width_p;
   localparam logic [CntW-1:0] FullCnt = CntW'(els_p);
   localparam logic [TagW-1:0] LastIdx = TagW'(num_in_p - 1);

   logic [TagW-1:0]    r_rr;
   logic [PtrW-1:0]    r_rd_ptr;
   logic [PtrW-1:0]    r_wr_ptr;
   logic [CntW-1:0]    r_count;
   logic [EntW-1:0]    r_mem [els_p];

   logic               w_any;
   logic [TagW-1:0]    w_scan;
   logic [TagW-1:0]    w_gnt_idx;
   logic [width_p-1:0] w_gnt_data;
   logic [EntW-1:0]    w_head;
   logic               w_full;
   logic               w_nonempty;
   logic               w_enq;
   logic               w_bypass;
   logic               w_store;
   logic               w_pop;

   // Find the first valid requester scanning upward from r_rr with wrap-around
   always_comb begin
      w_any     = 1'b0;
      w_scan    = '0;
      w_gnt_idx = '0;
      for (int unsigned i = 0; i < num_in_p; i++) begin
         w_scan = TagW'((32'(r_rr) + i) % num_in_p);
         if (!w_any && v_i[w_scan]) begin
            w_any     = 1'b1;
            w_gnt_idx = w_scan;
         end
      end
   end

   // Select the granted requester's payload lane
   always_comb begin
      w_gnt_data = '0;
      for (int unsigned k = 0; k < num_in_p; k++) begin
         if (w_gnt_idx == TagW'(k)) w_gnt_data = data_i[k*width_p +: width_p];
      end
   end

   assign w_full     = (r_count == FullCnt);
   assign w_nonempty = (r_count != '0);
   assign w_head     = r_mem[r_rd_ptr];
   // Gating with reset_n_i keeps ready_o/v_o low during reset whatever v_i does
   assign w_enq      = reset_n_i & w_any & ~w_full;
   assign w_pop      = yumi_i & w_nonempty;
   assign w_store    = w_enq & ~w_bypass;
   assign count_o    = r_count;

   // One-hot grant, suppressed when full; never depends on yumi_i
   always_comb begin
      ready_o = '0;
      if (w_enq) ready_o[w_gnt_idx] = 1'b1;
   end

   // Head presentation: storage first, otherwise the word currently being granted
   always_comb begin
`ifdef BSG_FIFO_BYPASS_RR_SCHED_BYPASS_EN
      w_bypass = w_enq & ~w_nonempty & yumi_i;
      v_o      = w_nonempty | w_enq;
      if (w_nonempty) {tag_o, data_o} = w_head;
      else            {tag_o, data_o} = {w_gnt_idx, w_gnt_data};
`else
      w_bypass        = 1'b0;
      v_o             = w_nonempty;
      {tag_o, data_o} = w_head;
`endif
   end

   // Pointers, occupancy and round-robin pointer
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_rr     <= '0;
      end else begin
         if (w_store) r_wr_ptr <= r_wr_ptr + PtrW'(1);
         if (w_pop)   r_rd_ptr <= r_rd_ptr + PtrW'(1);
         unique case ({w_store, w_pop})
            2'b10:   r_count <= r_count + CntW'(1);
            2'b01:   r_count <= r_count - CntW'(1);
            default: r_count <= r_count;
         endcase
         if (w_enq) r_rr <= (w_gnt_idx == LastIdx) ? '0 : w_gnt_idx + TagW'(1);
      end
   end

   // Storage array; contents need no reset since occupancy gates visibility
   always_ff @(posedge clk_i) begin
      if (w_store) r_mem[r_wr_ptr] <= {w_gnt_idx, w_gnt_data};
   end

`ifndef SYNTHESIS
   // Consumer must not take a word that is not offered
   a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
      else $error("yumi_i asserted while v_o is low");
`endif

endmodule

// File: tb/tb_bsg_fifo_bypass_rr_sched.sv
// Self-checking bench: directed scenarios plus random traffic compared with a queue model.
module tb_bsg_fifo_bypass_rr_sched;

   localparam int W = 8;
   localparam int N = 4;
   localparam int E = 4;
`ifdef BSG_FIFO_BYPASS_RR_SCHED_BYPASS_EN
   localparam bit Byp = 1'b1;
`else
   localparam bit Byp = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic [N*W-1:0] data_i;
   logic [N-1:0]  v_i;
   logic [N-1:0]  ready_o;
   logic [W-1:0]  data_o;
   logic [1:0]    tag_o;
   logic          v_o;
   logic          yumi_i;
   logic [2:0]    count_o;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: FIFO of {tag, data} and next-favoured requester
   logic [9:0] m_q[$];
   int         m_rr = 0;

   always #5 clk = ~clk;

   bsg_fifo_bypass_rr_sched #(
      .width_p  (W),
      .num_in_p (N),
      .els_p    (E)
   ) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .data_i    (data_i),
      .v_i       (v_i),
      .ready_o   (ready_o),
      .data_o    (data_o),
      .tag_o     (tag_o),
      .v_o       (v_o),
      .yumi_i    (yumi_i),
      .count_o   (count_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // One clock cycle: drive inputs, check outputs against the model, then advance the model
   task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, input bit want_yumi);
      int         g;
      bit         any;
      bit         enq;
      bit         exp_v;
      bit         bypassed;
      logic [3:0] exp_rdy;
      logic [7:0] exp_d;
      logic [1:0] exp_t;
      logic [1:0] g2;
      @(negedge clk);
      any = 1'b0;
      g   = 0;
      for (int i = 0; i < N; i++) begin
         int k;
         k = (m_rr + i) % N;
         if (!any && v[k]) begin
            any = 1'b1;
            g   = k;
         end
      end
      g2      = g[1:0];
      enq     = any && (m_q.size() < E);
      exp_rdy = enq ? (4'b0001 << g) : 4'b0000;
      exp_d   = '0;
      exp_t   = '0;
      if (Byp) exp_v = (m_q.size() > 0) || enq;
      else     exp_v = (m_q.size() > 0);
      if (m_q.size() > 0) {exp_t, exp_d} = m_q[0];
      else if (Byp && enq) begin
         exp_t = g2;
         exp_d = d[g*W +: W];
      end
      v_i    = v;
      data_i = d;
      yumi_i = want_yumi && exp_v;
      #1;
      check("ready", 32'(ready_o), 32'(exp_rdy));
      check("v_o", 32'(v_o), 32'(exp_v));
      check("count", 32'(count_o), 32'(m_q.size()));
      if (exp_v) begin
         check("data", 32'(data_o), 32'(exp_d));
         check("tag", 32'(tag_o), 32'(exp_t));
      end
      bypassed = Byp && enq && (m_q.size() == 0) && yumi_i;
      if (!bypassed) begin
         if (yumi_i && m_q.size() > 0) void'(m_q.pop_front());
         if (enq) m_q.push_back({g2, d[g*W +: W]});
      end
      if (enq) m_rr = (g + 1) % N;
   endtask

   task automatic drain();
      for (int i = 0; i < E + 2; i++) cycle(4'b0000, '0, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with all requesters valid
      reset_n = 1'b0;
      v_i     = 4'b1111;
      data_i  = $urandom;
      yumi_i  = 1'b0;
      #12;
      check("rst_ready", 32'(ready_o), 32'h0);
      check("rst_v_o", 32'(v_o), 32'h0);
      check("rst_count", 32'(count_o), 32'h0);
      @(negedge clk);
      v_i     = 4'b0000;
      reset_n = 1'b1;

      // Round-robin with continuous consumption; first grant is requester 0
      for (int i = 0; i < 6; i++) cycle(4'b1111, $urandom, 1'b1);
      drain();

      // Single requester on lane 2
      cycle(4'b0100, 32'h00A5_0000, 1'b1);
      cycle(4'b0000, '0, 1'b1);
      cycle(4'b0000, '0, 1'b1);

      // Fill to full, then start consuming
      for (int i = 0; i < 5; i++) cycle(4'b0011, $urandom, 1'b0);
      cycle(4'b0011, $urandom, 1'b1);
      cycle(4'b0011, $urandom, 1'b1);
      drain();

      // Wrap-around with interleaved consumption
      for (int i = 0; i < 24; i++) cycle(4'b0001 << $urandom_range(0, 3), $urandom, i[0]);
      drain();

      // Random traffic
      for (int i = 0; i < 400; i++) cycle(4'($urandom), $urandom, ($urandom_range(0, 3) != 0));
      drain();

      // Asynchronous reset while three words are stored
      for (int i = 0; i < 3; i++) cycle(4'b0001, $urandom, 1'b0);
      @(negedge clk);
      v_i    = 4'b1111;
      yumi_i = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_v_o", 32'(v_o), 32'h0);
      check("mid_rst_count", 32'(count_o), 32'h0);
      check("mid_rst_ready", 32'(ready_o), 32'h0);
      @(negedge clk);
      v_i     = 4'b0000;
      reset_n = 1'b1;
      m_q.delete();
      m_rr = 0;
      for (int i = 0; i < 3; i++) cycle(4'b0000, '0, 1'b1);
      cycle(4'b1010, $urandom, 1'b1);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
